// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V run controller: state encoding and default sizes
// that are also used by the core top level.
package riscv_ctrl_pkg;

  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 32;
  localparam int CNT_W_DEF        = 32;
  localparam int MAX_CYCLES_DEF   = 1000000;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // The core owns the data-memory port (and is out of reset) only while running or draining.
  function automatic logic core_owns_mem(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter with synchronous clear and saturation at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLOCK_50,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (en && (cnt_reg != '1))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for the pipelined core: sequences reset/run/drain/done and arbitrates the
// single data-memory port between the host loader and the core's MEM stage.
module riscv_run_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              CLOCK_50,
  input  logic              rstn,
  input  logic              start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              cpu_rstn,
  input  logic              cpu_done,
  input  logic [CNT_W-1:0]  cpu_instr_count,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  output logic [DATA_W-1:0] cpu_mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              run_done,
  output logic              timeout,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [CNT_W-1:0]  run_instrs
);

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam int CNT_RUN   = 0;
  localparam int CNT_DRAIN = 1;
  localparam int N_CNT     = 2;

  state_t state_reg, state_next;

  logic             start_ok;
  logic             to_done;
  logic             cpu_rstn_reg;
  logic             host_rvalid_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] run_instrs_reg;

  logic [N_CNT-1:0] cnt_clr;
  logic [N_CNT-1:0] cnt_en;
  logic [CNT_W-1:0] cnt_val [N_CNT];

  assign start_ok = start && !core_owns_mem(state_reg);
  assign to_done  = (state_next == ST_DONE) && (state_reg != ST_DONE);

  // Run counter restarts on every accepted start; drain counter is held at zero outside DRAIN.
  assign cnt_clr[CNT_RUN]   = start_ok;
  assign cnt_en[CNT_RUN]    = (state_reg == ST_RUN);
  assign cnt_clr[CNT_DRAIN] = (state_reg != ST_DRAIN);
  assign cnt_en[CNT_DRAIN]  = (state_reg == ST_DRAIN);

  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .CLOCK_50(CLOCK_50),
        .rstn    (rstn),
        .clr     (cnt_clr[gi]),
        .en      (cnt_en[gi]),
        .cnt     (cnt_val[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // cpu_done is tested before the cycle limit so a done flag on the last allowed cycle drains.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (cpu_done)
          state_next = ST_DRAIN;
        else if (cnt_val[CNT_RUN] == RUN_LAST)
          state_next = ST_DONE;
      end
      ST_DRAIN: if (cnt_val[CNT_DRAIN] == DRAIN_LAST) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    host_gnt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (core_owns_mem(state_reg)) begin
      mem_we    = cpu_mem_we;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
    end else begin
      host_gnt = host_req;
      mem_we   = host_req & host_we;
    end
    // No grant or memory write may slip out while reset is asserted.
    if (!rstn) begin
      host_gnt = 1'b0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      cpu_rstn_reg    <= 1'b0;
      host_rvalid_reg <= 1'b0;
      timeout_reg     <= 1'b0;
      run_instrs_reg  <= '0;
    end else begin
      cpu_rstn_reg    <= core_owns_mem(state_next);
      host_rvalid_reg <= host_gnt & ~host_we;
      if (start_ok) begin
        timeout_reg    <= 1'b0;
        run_instrs_reg <= '0;
      end else if (to_done) begin
        run_instrs_reg <= cpu_instr_count;
        if (state_reg == ST_RUN)
          timeout_reg <= 1'b1;
      end
    end
  end

  assign cpu_rstn      = cpu_rstn_reg;
  assign host_rvalid   = host_rvalid_reg;
  assign host_rdata    = mem_rdata;
  assign cpu_mem_rdata = mem_rdata;
  assign busy          = core_owns_mem(state_reg);
  assign run_done      = (state_reg == ST_DONE);
  assign timeout       = timeout_reg;
  assign run_cycles    = cnt_val[CNT_RUN];
  assign run_instrs    = run_instrs_reg;

endmodule
